// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage in front of the instruction cache. Holds the
// program counter, presents it to the cache as the read address and captures
// the word the cache returns in the same cycle into a small prefetch FIFO.
// Decode pulls {pc, instruction} pairs from the FIFO head. A redirect from
// execute flushes the FIFO and restarts fetch at the new target.
//
// Optional feature (macro FETCH_ALIGN_CHECK_EN):
//   A redirect to a target whose bits [1:0] are not zero raises o_fault and
//   halts fetch until the next aligned redirect. Without the macro, o_fault
//   is tied 0 and a misaligned target is fetched with bits [1:0] cleared.
//
// Parameters:
//   RESET_PC    PC loaded at reset (defaults to `_INST_CACHE_OFFSET)
//   FIFO_DEPTH  prefetch entries, power of two, 2..16
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   o_cache_address  cache read address (the PC register)
//   o_cache_op_type  cache operation, always read (0)
//   o_cache_val      cache write data, always 0
//   i_cache_val      word returned combinationally for o_cache_address
//   o_valid          FIFO head holds a valid entry
//   o_inst           instruction at the FIFO head (0 when empty)
//   o_pc             PC of the FIFO head (0 when empty)
//   i_ready          decode accepts the head this cycle
//   i_redirect       flush the FIFO and restart fetch
//   i_redirect_pc    restart target
//   o_fault          misaligned-redirect fault
// ---------------------------------------------------------------------------

`ifndef _INST_CACHE_OFFSET
`define _INST_CACHE_OFFSET 32'h0000_0000
`endif

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = `_INST_CACHE_OFFSET,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_cache_address,
    output logic        o_cache_op_type,
    output logic [31:0] o_cache_val,
    input  logic [31:0] i_cache_val,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault
);

    localparam int             PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

    logic [31:0]      pc;
    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             halted;
    logic             pop;
    logic             push;

    // Handshake: the head entry transfers to decode on a rising edge where
    // o_valid and i_ready are both high and i_redirect is low. o_valid never
    // depends on i_ready; i_ready while o_valid is low has no effect, and a
    // redirect discards the head even if i_ready is high.
    assign pop  = o_valid & i_ready;
    // A full FIFO can still accept a word in a cycle where the head leaves.
    assign push = ~i_redirect & ~halted & ((count < DEPTH_CNT) | pop);

    assign o_cache_address = pc;
    assign o_cache_op_type = 1'b0;
    assign o_cache_val     = 32'h0000_0000;

    // Head outputs come from registered FIFO state only; zeroed when empty.
    assign o_valid = (count != '0);
    assign o_pc    = o_valid ? mem[rd_ptr][63:32] : 32'h0000_0000;
    assign o_inst  = o_valid ? mem[rd_ptr][31:0]  : 32'h0000_0000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_redirect) begin
            // Target is always word-aligned; low bits are dropped here and,
            // when the alignment check is built in, reported as a fault.
            pc     <= i_redirect_pc & ~32'h0000_0003;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {pc, i_cache_val};
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Fault and halt are the same condition: set by a misaligned redirect,
    // cleared only by an aligned one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            halted <= 1'b0;
        end else if (i_redirect) begin
            halted <= |i_redirect_pc[1:0];
        end
    end
    assign o_fault = halted;
`else
    assign halted  = 1'b0;
    assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Bench for inst_fetch_unit. The reference model is a queue of the entries
// the FIFO should hold plus the expected PC. The driver issues one cycle of
// stimulus at a time and, at the clock edge, appends the entry fetched that
// cycle (or flushes on redirect). The monitor, on every falling edge,
// compares the DUT head against the queue front and pops it when decode is
// accepting.
// ---------------------------------------------------------------------------

module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] o_cache_address;
    logic        o_cache_op_type;
    logic [31:0] o_cache_val;
    logic [31:0] i_cache_val;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_fault;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .o_cache_address (o_cache_address),
        .o_cache_op_type (o_cache_op_type),
        .o_cache_val     (o_cache_val),
        .i_cache_val     (i_cache_val),
        .o_valid         (o_valid),
        .o_inst          (o_inst),
        .o_pc            (o_pc),
        .i_ready         (i_ready),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_fault         (o_fault)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- cache model ----------------
    function automatic logic [31:0] cache_word(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    assign i_cache_val = cache_word(o_cache_address);

    // ---------------- reference model / scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic        m_halted;
    logic        mon_en;
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the model between edges.
    always @(negedge i_clk) begin
        if (mon_en) begin
            check("valid", {31'b0, o_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("head_pc", o_pc, exp_q[0][63:32]);
                check("head_inst", o_inst, exp_q[0][31:0]);
                if (i_ready && !i_redirect) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                check("empty_pc", o_pc, 32'h0);
                check("empty_inst", o_inst, 32'h0);
            end
            check("cache_address", o_cache_address, m_pc);
            check("fault", {31'b0, o_fault}, {31'b0, m_halted});
            check("cache_op", {31'b0, o_cache_op_type}, 32'h0);
            check("cache_val", o_cache_val, 32'h0);
        end
    end

    // ---------------- driver ----------------
    // Drives inputs just after an edge, then advances the model at the next
    // edge. The monitor has already removed any entry consumed at that edge,
    // so "room in the queue" covers the full-and-pop case.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
        i_ready       = rdy;
        i_redirect    = redir;
        i_redirect_pc = tgt;
        @(posedge i_clk);
        if (redir) begin
            exp_q.delete();
            m_pc = tgt & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
            m_halted = (tgt[1:0] != 2'b00);
`endif
        end else if (!m_halted && exp_q.size() < DEPTH) begin
            exp_q.push_back({m_pc, cache_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic async_reset();
        mon_en = 1'b0;
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, o_valid}, 32'h0);
        check("arst_cache_address", o_cache_address, RESET_PC);
        check("arst_pc", o_pc, 32'h0);
        check("arst_inst", o_inst, 32'h0);
        check("arst_fault", {31'b0, o_fault}, 32'h0);
        exp_q.delete();
        m_pc       = RESET_PC;
        m_halted   = 1'b0;
        i_ready    = 1'b0;
        i_redirect = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        mon_en        = 1'b0;
        m_pc          = RESET_PC;
        m_halted      = 1'b0;
        i_rst_n       = 1'b0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;

        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_fault", {31'b0, o_fault}, 32'h0);
        check("rst_cache_address", o_cache_address, RESET_PC);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Free fetch from reset, decode always ready.
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Back-pressure to full, then drain.
        step(1'b0, 1'b1, 32'h0);
        repeat (8) step(1'b0, 1'b0, 32'h0);
        check("full_cache_address", o_cache_address, 32'h0000_0010);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        // Redirect while decode is accepting a 3-entry FIFO.
        step(1'b0, 1'b1, 32'h0);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0100);
        check("redir_valid", {31'b0, o_valid}, 32'h0);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // PC wrap across 2^32.
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (5) step(1'b1, 1'b0, 32'h0);

        // Asynchronous reset with two entries held.
        step(1'b0, 1'b1, 32'h0000_0040);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        async_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0);

        // Misaligned redirect, then aligned recovery.
        step(1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misaligned_fault", {31'b0, o_fault}, 32'h1);
`endif
        repeat (3) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0200);
        check("aligned_fault_clear", {31'b0, o_fault}, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        redir;
            logic [31:0] tgt;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: tgt = 32'($urandom_range(0, 255)) << 2;
            endcase
            step(rdy, redir, tgt);
        end

        mon_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage that sits directly upstream of the instruction cache. It owns the program counter, drives read addresses into the cache, and captures the returned words into a small prefetch FIFO. It hands {pc, instruction} pairs to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the new target.

## Interface
Parameters:
- RESET_PC, `_INST_CACHE_OFFSET`: PC loaded at reset.
- FIFO_DEPTH, 4: prefetch entries; power of two, 2..16.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- o_cache_address  output  32  read address to the instruction cache; equals the PC register.
- o_cache_op_type  output  1  constant 0 (read).
- o_cache_val  output  32  constant 0.
- i_cache_val  input  32  instruction word returned combinationally by the cache for o_cache_address.
- o_valid  output  1  FIFO head holds a valid entry.
- o_inst  output  32  instruction at the FIFO head.
- o_pc  output  32  PC of the FIFO head.
- i_ready  input  1  decode accepts the head this cycle.
- i_redirect  input  1  flush and restart fetch.
- i_redirect_pc  input  32  restart target.
- o_fault  output  1  misaligned-redirect fault. Exists only with the macro below; otherwise tied 0.

## Operation
- State: pc[31:0], FIFO storage of FIFO_DEPTH × 64 bits, read/write pointers, count[log2(FIFO_DEPTH):0].
- pop = o_valid & i_ready.
- push = !i_redirect & !halted & (count < FIFO_DEPTH | pop).
- On push:
  - write {pc, i_cache_val} at the write pointer;
  - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0;
  - advance the write pointer.
- On pop: advance the read pointer.
- count updates as count + push − pop.
- Pointers wrap modulo FIFO_DEPTH.
- Redirect has priority over everything:
  - count <= 0 and both pointers <= 0;
  - pc <= i_redirect_pc with bits [1:0] cleared;
  - no push and no pop that cycle; an asserted i_ready is ignored and the head entry is discarded.
- Full and pop in the same cycle: push still occurs and count stays at FIFO_DEPTH.
- Empty: o_valid=0, o_inst=0, o_pc=0. i_ready is ignored.
- halted is 0 unless the configuration feature sets it.

## Timing
- Reset values:
  - pc = RESET_PC;
  - count = 0, both pointers = 0;
  - o_valid = 0, o_inst = 0, o_pc = 0, o_fault = 0;
  - o_cache_address = RESET_PC.
- Reset asserted mid-operation clears all of the above immediately; no clock is needed.
- The cache read is combinational, so fetch throughput is one word per cycle while the FIFO is not full.
- Latency from the pc update to o_valid: 1 edge. The first edge after reset release pushes the RESET_PC entry, and o_valid rises after that edge.
- Latency from redirect to o_valid: 2 edges. Edge 1 flushes and loads the pc; edge 2 pushes the target entry.
- Outputs o_valid, o_inst and o_pc come from registered FIFO state only, with no combinational path from i_ready or i_redirect.
- o_cache_address is the pc register with no combinational inputs.

## Configuration
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - a redirect with i_redirect_pc[1:0] != 0 sets o_fault and halted on that edge, and loads pc with bits [1:0] cleared;
  - while halted, no pushes occur; existing entries are already flushed;
  - the next aligned redirect clears o_fault and halted and resumes fetch;
  - a misaligned redirect while halted keeps the unit halted.
- Not defined:
  - o_fault is tied 0 and halted is always 0;
  - a misaligned target silently fetches from the target with bits [1:0] cleared.

## Test plan
- Reset and free fetch:
  - stimulus: RESET_PC=0, cache returns 32'hA000_0000+address, i_ready=1;
  - required: o_valid rises after the first edge; the pc/inst sequence is 0/A000_0000, 4/A000_0004, 8/A000_0008; one entry per cycle.
- Back-pressure to full:
  - stimulus: hold i_ready=0 for 8 cycles, then assert i_ready=1;
  - required: count saturates at 4 and o_cache_address holds at 16; on release, entries 0, 4, 8, 12, then 16 come out in order with no loss or duplication.
- Redirect with a simultaneous pop:
  - stimulus: FIFO holding 3 entries, i_ready=1, i_redirect=1, i_redirect_pc=32'h0000_0100;
  - required: the head is not consumed; o_valid=0 on the next cycle; the next entry out is pc 0x100.
- PC wrap:
  - stimulus: redirect to 32'hFFFF_FFF8;
  - required: the output pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Asynchronous reset mid-stream:
  - stimulus: drop i_rst_n between edges while the FIFO holds 2 entries;
  - required: o_valid=0 and o_cache_address=RESET_PC before the next edge.
- With FETCH_ALIGN_CHECK_EN:
  - stimulus: redirect to 32'h102;
  - required: o_fault=1 and no valid entries while halted; a subsequent redirect to 32'h200 clears o_fault and the first entry out is pc 0x200.
